urv_iram_port_arb: RTL and testbench

Two-requester arbiter for port B of the dual-port instruction/data RAM. It shares the single RAM port between the CPU data-memory interface and a host/debug loader port. Fixed priority goes to the host, with a starvation counter that guarantees CPU progress. A lock input gives the host exclusive access during program download. The block sits between the CPU load/store unit, the host bridge and RAM port B; port A (instruction fetch) is untouched.

---
 rtl/urv_iram_port_arb_pkg.sv | 16 +
 rtl/urv_iram_port_arb_if.sv | 51 +++++
 rtl/urv_arb2.sv | 50 +++++
 rtl/urv_iram_port_arb.sv | 76 +++++++
 tb/tb_urv_iram_port_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/urv_iram_port_arb_pkg.sv
// Shared types and helpers for the port-B instruction/data RAM arbiter.
package urv_iram_port_arb_pkg;

  // Owner of the read whose data returns in the following cycle.
  typedef enum logic [1:0] {
    RdNone = 2'd0,
    RdCpu  = 2'd1,
    RdHost = 2'd2
  } rd_owner_e;

  // Starvation counter width; at least one bit so a zero limit stays legal.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/urv_iram_port_arb_if.sv
// Bus bundle for the port-B arbiter: CPU side, host side and RAM port B.
interface urv_iram_port_arb_if #(
  parameter int unsigned g_addr_width = 32
);
  logic                    cpu_req_i;
  logic                    cpu_we_i;
  logic [g_addr_width-1:0] cpu_addr_i;
  logic [3:0]              cpu_bwe_i;
  logic [31:0]             cpu_data_i;
  logic                    cpu_gnt_o;
  logic                    cpu_rvalid_o;
  logic [31:0]             cpu_rdata_o;

  logic                    host_req_i;
  logic                    host_we_i;
  logic [g_addr_width-1:0] host_addr_i;
  logic [3:0]              host_bwe_i;
  logic [31:0]             host_data_i;
  logic                    host_gnt_o;
  logic                    host_rvalid_o;
  logic [31:0]             host_rdata_o;
  logic                    host_lock_i;

  logic                    ram_en_o;
  logic                    ram_we_o;
  logic [g_addr_width-1:0] ram_addr_o;
  logic [3:0]              ram_bwe_o;
  logic [31:0]             ram_data_o;
  logic [31:0]             ram_q_i;

  // Arbiter side.
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_bwe_i, cpu_data_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    input  host_req_i, host_we_i, host_addr_i, host_bwe_i, host_data_i, host_lock_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_bwe_o, ram_data_o,
    input  ram_q_i
  );

  // Requester / RAM side.
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_bwe_i, cpu_data_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    output host_req_i, host_we_i, host_addr_i, host_bwe_i, host_data_i, host_lock_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_bwe_o, ram_data_o,
    output ram_q_i
  );

endinterface

// File: rtl/urv_arb2.sv
// Two-way fixed-priority arbiter: the high requester wins unless the low
// requester has been denied g_starve_limit consecutive cycles. Lock blocks
// the low requester entirely and freezes its starvation count.
module urv_arb2
  import urv_iram_port_arb_pkg::*;
#(
  parameter int unsigned g_starve_limit = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_hi,
  input  logic       req_lo,
  input  logic       lock,
  output logic [1:0] gnt    // [0] high requester, [1] low requester
);

  localparam int unsigned     CntW  = cnt_width(g_starve_limit);
  localparam logic [CntW-1:0] Limit = CntW'(g_starve_limit);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_limit;
  logic            lo_win;
  logic            hi_win;

  // Winner selection and starvation counter next state.
  always_comb begin
    at_limit = (g_starve_limit != 0) && (cnt_q == Limit);
    // Grants are forced low while reset is held.
    lo_win   = rst_n_i && req_lo && !lock && (!req_hi || at_limit);
    hi_win   = rst_n_i && req_hi && !lo_win;
    gnt      = {lo_win, hi_win};

    cnt_d = cnt_q;
    if (lo_win) begin
      cnt_d = '0;
    end else if (req_lo && !lock && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/urv_iram_port_arb.sv
// Port-B arbiter between CPU data accesses and the host loader. Muxes the
// winner onto RAM port B and routes read data back one cycle later.
module urv_iram_port_arb
  import urv_iram_port_arb_pkg::*;
#(
  parameter int unsigned g_starve_limit = 8,
  parameter int unsigned g_addr_width   = 32
) (
  input logic               clk_i,
  input logic               rst_n_i,
  urv_iram_port_arb_if.slave bus
);

  logic [1:0]              gnt;
  logic [g_addr_width-1:0] addr_mux;
  rd_owner_e               rd_owner_q, rd_owner_d;

  urv_arb2 #(
    .g_starve_limit(g_starve_limit)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .req_hi (bus.host_req_i),
    .req_lo (bus.cpu_req_i),
    .lock   (bus.host_lock_i),
    .gnt    (gnt)
  );

  // Grant outputs and RAM port mux; host fields are the idle default.
  always_comb begin
    bus.host_gnt_o = gnt[0];
    bus.cpu_gnt_o  = gnt[1];
    bus.ram_en_o   = |gnt;
    bus.ram_we_o   = 1'b0;
    addr_mux       = bus.host_addr_i;
    bus.ram_bwe_o  = bus.host_bwe_i;
    bus.ram_data_o = bus.host_data_i;
    if (gnt[1]) begin
      bus.ram_we_o   = bus.cpu_we_i;
      addr_mux       = bus.cpu_addr_i;
      bus.ram_bwe_o  = bus.cpu_bwe_i;
      bus.ram_data_o = bus.cpu_data_i;
    end else if (gnt[0]) begin
      bus.ram_we_o = bus.host_we_i;
    end
    bus.ram_addr_o = addr_mux;
  end

  // Next read owner: whoever was granted a read this cycle.
  always_comb begin
    rd_owner_d = RdNone;
    if (gnt[1] && !bus.cpu_we_i) begin
      rd_owner_d = RdCpu;
    end else if (gnt[0] && !bus.host_we_i) begin
      rd_owner_d = RdHost;
    end
  end

  // Read owner register; reset drops any pending read return.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_owner_q <= RdNone;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Read data return, zeroed for the non-owner.
  always_comb begin
    bus.cpu_rvalid_o  = (rd_owner_q == RdCpu);
    bus.host_rvalid_o = (rd_owner_q == RdHost);
    bus.cpu_rdata_o   = bus.cpu_rvalid_o ? bus.ram_q_i : 32'h0;
    bus.host_rdata_o  = bus.host_rvalid_o ? bus.ram_q_i : 32'h0;
  end

endmodule

// File: tb/tb_urv_iram_port_arb.sv
// Directed bench for urv_iram_port_arb with a behavioural RAM on port B.
module tb_urv_iram_port_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:255];

  urv_iram_port_arb_if #(.g_addr_width(32)) bus ();
  urv_iram_port_arb_if #(.g_addr_width(32)) bus0 ();

  urv_iram_port_arb #(
    .g_starve_limit(8),
    .g_addr_width  (32)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  urv_iram_port_arb #(
    .g_starve_limit(0),
    .g_addr_width  (32)
  ) dut_z (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus0)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: byte-enabled write, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_bwe_o[b]) mem[bus.ram_addr_o[9:2]][8*b +: 8] <= bus.ram_data_o[8*b +: 8];
        end
      end else begin
        bus.ram_q_i <= mem[bus.ram_addr_o[9:2]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = 32'h0;
    bus.cpu_bwe_i   = 4'h0;
    bus.cpu_data_i  = 32'h0;
    bus.host_req_i  = 1'b0;
    bus.host_we_i   = 1'b0;
    bus.host_addr_i = 32'h0;
    bus.host_bwe_i  = 4'h0;
    bus.host_data_i = 32'h0;
    bus.host_lock_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.cpu_req_i  = 1'b1;
    bus.host_req_i = 1'b1;
    #2;
    checks++;
    if ({bus.cpu_gnt_o, bus.host_gnt_o, bus.ram_en_o, bus.ram_we_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt_en: got %b want 0000",
               {bus.cpu_gnt_o, bus.host_gnt_o, bus.ram_en_o, bus.ram_we_o});
    end
    checks++;
    if ({bus.cpu_rvalid_o, bus.host_rvalid_o, bus.cpu_rdata_o, bus.host_rdata_o} !== 66'h0) begin
      errors++;
      $display("FAIL reset_rvalid_rdata: got %b %b %h %h want 0 0 0 0", bus.cpu_rvalid_o,
               bus.host_rvalid_o, bus.cpu_rdata_o, bus.host_rdata_o);
    end
    checks++;
    if (dut.u_arb.cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", dut.u_arb.cnt_q);
    end
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    tick();
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h100;
    #1;
    checks++;
    if ({bus.cpu_gnt_o, bus.host_gnt_o, bus.ram_en_o, bus.ram_we_o} !== 4'b1010 ||
        bus.ram_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL cpu_read_gnt: got gnt/en/we %b addr %h want 1010 addr 00000100",
               {bus.cpu_gnt_o, bus.host_gnt_o, bus.ram_en_o, bus.ram_we_o}, bus.ram_addr_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.cpu_rvalid_o !== 1'b1 || bus.cpu_rdata_o !== 32'hDEADBEEF ||
        bus.host_rvalid_o !== 1'b0 || bus.host_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL cpu_read_data: got %b %h host %b %h want 1 deadbeef host 0 00000000",
               bus.cpu_rvalid_o, bus.cpu_rdata_o, bus.host_rvalid_o, bus.host_rdata_o);
    end
    tick();
    checks++;
    if (bus.cpu_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_single: got rvalid %b want 0", bus.cpu_rvalid_o);
    end
  endtask

  task automatic test_starvation();
    logic exp;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_addr_i  = 32'h100;
    bus.host_req_i  = 1'b1;
    bus.host_addr_i = 32'h40;
    for (int i = 0; i < 27; i++) begin
      #1;
      exp = ((i % 9) == 8);
      checks++;
      if (bus.cpu_gnt_o !== exp || bus.host_gnt_o !== !exp) begin
        errors++;
        $display("FAIL starve_cycle%0d: got cpu %b host %b want cpu %b host %b", i,
                 bus.cpu_gnt_o, bus.host_gnt_o, exp, !exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock();
    logic exp;
    bus.cpu_req_i  = 1'b1;
    bus.host_req_i = 1'b1;
    tick();
    tick();
    tick();
    bus.host_req_i  = 1'b0;
    bus.host_lock_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (bus.cpu_gnt_o !== 1'b0 || bus.ram_en_o !== 1'b0 || dut.u_arb.cnt_q !== 4'd3) begin
        errors++;
        $display("FAIL lock_cycle%0d: got gnt %b en %b cnt %0d want 0 0 3", i,
                 bus.cpu_gnt_o, bus.ram_en_o, dut.u_arb.cnt_q);
      end
      tick();
    end
    // Release with host contending: counter resumes from 3, five more host wins.
    bus.host_lock_i = 1'b0;
    bus.host_req_i  = 1'b1;
    for (int j = 0; j < 6; j++) begin
      #1;
      exp = (j == 5);
      checks++;
      if (bus.cpu_gnt_o !== exp) begin
        errors++;
        $display("FAIL lock_resume%0d: got cpu gnt %b want %b", j, bus.cpu_gnt_o, exp);
      end
      tick();
    end
    bus.host_req_i  = 1'b0;
    bus.host_lock_i = 1'b1;
    tick();
    tick();
    bus.host_lock_i = 1'b0;
    #1;
    checks++;
    if (bus.cpu_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL lock_release_gnt: got %b want 1", bus.cpu_gnt_o);
    end
    tick();
    idle();
  endtask

  task automatic test_write_then_read();
    tick();
    bus.host_req_i  = 1'b1;
    bus.host_we_i   = 1'b1;
    bus.host_addr_i = 32'h40;
    bus.host_bwe_i  = 4'b0011;
    bus.host_data_i = 32'h12345678;
    #1;
    checks++;
    if ({bus.host_gnt_o, bus.ram_en_o, bus.ram_we_o, bus.ram_bwe_o} !== 7'b1110011 ||
        bus.ram_data_o !== 32'h12345678) begin
      errors++;
      $display("FAIL host_write: got gnt/en/we/bwe %b data %h want 1110011 12345678",
               {bus.host_gnt_o, bus.ram_en_o, bus.ram_we_o, bus.ram_bwe_o}, bus.ram_data_o);
    end
    tick();
    idle();
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h40;
    #1;
    checks++;
    if (bus.host_rvalid_o !== 1'b0 || bus.cpu_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL write_no_rvalid: got host rvalid %b cpu gnt %b want 0 1",
               bus.host_rvalid_o, bus.cpu_gnt_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.cpu_rvalid_o !== 1'b1 || bus.cpu_rdata_o !== 32'hAABB5678) begin
      errors++;
      $display("FAIL merged_read: got %b %h want 1 aabb5678", bus.cpu_rvalid_o, bus.cpu_rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    bus.host_req_i  = 1'b1;
    bus.host_addr_i = 32'h100;
    tick();
    idle();
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h40;
    #1;
    checks++;
    if (bus.host_rvalid_o !== 1'b1 || bus.host_rdata_o !== 32'hDEADBEEF ||
        bus.cpu_rvalid_o !== 1'b0 || bus.cpu_rdata_o !== 32'h0 || bus.cpu_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_host: got host %b %h cpu %b %h gnt %b want 1 deadbeef 0 0 1",
               bus.host_rvalid_o, bus.host_rdata_o, bus.cpu_rvalid_o, bus.cpu_rdata_o,
               bus.cpu_gnt_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.cpu_rvalid_o !== 1'b1 || bus.cpu_rdata_o !== 32'hAABB5678 ||
        bus.host_rvalid_o !== 1'b0 || bus.host_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL b2b_cpu: got cpu %b %h host %b %h want 1 aabb5678 0 0",
               bus.cpu_rvalid_o, bus.cpu_rdata_o, bus.host_rvalid_o, bus.host_rdata_o);
    end
  endtask

  task automatic test_reset_mid_read();
    tick();
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h100;
    #1;
    checks++;
    if (bus.cpu_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_gnt: got %b want 1", bus.cpu_gnt_o);
    end
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cpu_rvalid_o, bus.cpu_gnt_o, bus.ram_en_o, bus.ram_we_o} !== 4'b0000 ||
        bus.cpu_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got rvalid/gnt/en/we %b rdata %h want 0000 0",
               {bus.cpu_rvalid_o, bus.cpu_gnt_o, bus.ram_en_o, bus.ram_we_o}, bus.cpu_rdata_o);
    end
    tick();
    checks++;
    if (bus.cpu_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold: got rvalid %b want 0", bus.cpu_rvalid_o);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.cpu_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_gnt: got %b want 1", bus.cpu_gnt_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.cpu_rvalid_o !== 1'b1 || bus.cpu_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_release_read: got %b %h want 1 deadbeef", bus.cpu_rvalid_o,
               bus.cpu_rdata_o);
    end
  endtask

  task automatic test_limit_zero();
    bus0.cpu_req_i  = 1'b1;
    bus0.host_req_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      checks++;
      if (bus0.cpu_gnt_o !== 1'b0 || bus0.host_gnt_o !== 1'b1) begin
        errors++;
        $display("FAIL limit0_cycle%0d: got cpu %b host %b want 0 1", i, bus0.cpu_gnt_o,
                 bus0.host_gnt_o);
      end
      tick();
    end
    bus0.cpu_req_i  = 1'b0;
    bus0.host_req_i = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;  // byte address 0x100
    mem[8'h10] = 32'hAABBCCDD;  // byte address 0x40
    bus.ram_q_i      = 32'h0;
    bus0.ram_q_i     = 32'h0;
    bus0.cpu_req_i   = 1'b0;
    bus0.cpu_we_i    = 1'b0;
    bus0.cpu_addr_i  = 32'h0;
    bus0.cpu_bwe_i   = 4'h0;
    bus0.cpu_data_i  = 32'h0;
    bus0.host_req_i  = 1'b0;
    bus0.host_we_i   = 1'b0;
    bus0.host_addr_i = 32'h0;
    bus0.host_bwe_i  = 4'h0;
    bus0.host_data_i = 32'h0;
    bus0.host_lock_i = 1'b0;
    idle();
    test_reset();
    test_cpu_read();
    test_starvation();
    test_lock();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid_read();
    test_limit_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
